unreg_capture: RTL and testbench



---
 rtl/unreg_pkg.sv | 28 ++
 rtl/unreg_skid2.sv | 61 ++++++
 rtl/unreg_capture.sv | 96 +++++++++
 tb/tb_unreg_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unreg_pkg.sv
`default_nettype none
// unreg_pkg: shared types and the select/clear/invert word-formation rule.
package unreg_pkg;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [W_DEF-1:0] form_word(
    input logic [W_DEF-1:0] a,
    input logic [W_DEF-1:0] b,
    input logic             sel,
    input logic             clr,
    input logic             inv
  );
    logic [W_DEF-1:0] f;
    f = clr ? '0 : (sel ? b : a);
    return inv ? ~f : f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unreg_skid2.sv
`default_nettype none
// unreg_skid2: 2-entry FIFO; head register drives the output, tail holds the second word.
module unreg_skid2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign dout      = out_valid ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail  <= din;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // The tail always advances into the head on a pop.
          if (pop) begin
            head <= tail;
            if (push) tail <= din;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/unreg_capture.sv
`default_nettype none
// unreg_capture: handshaked word formation into a 2-entry FIFO under a burst controller.
module unreg_capture
  import unreg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             pstart,
  input  logic [CNT_W-1:0] plen,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  logic [W-1:0]     pa,
  input  logic [W-1:0]     pb,
  input  logic             psel,
  input  logic             pclr,
  input  logic             pinv,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [W-1:0]     pout,
  output logic             pbusy,
  output logic             pdone
);

  logic           rst_meta;
  logic           rst_sync_n;
  state_t         state;
  state_t         state_nxt;
  logic [CNT_W:0] remaining;
  logic [1:0]     fifo_count;
  logic           accept;
  logic           pop;
  logic [W-1:0]   word;

  // Reset asserts immediately and releases two edges later.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign word      = form_word(pa, pb, psel, pclr, pinv);
  assign pin_ready = (state == RUN) && (fifo_count < 2'd2) && (remaining != '0);
  assign accept    = pin_valid & pin_ready;
  assign pop       = pout_valid & pout_ready;
  assign pbusy     = (state != IDLE);

  always_ff @(posedge pclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pstart) begin
        remaining <= (plen == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, plen};
      end else if (accept) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pdone     = 1'b0;
    case (state)
      IDLE:  if (pstart) state_nxt = RUN;
      RUN:   if (accept && remaining == {{CNT_W{1'b0}}, 1'b1}) state_nxt = DRAIN;
      // No pushes happen in DRAIN, so a pop at count 1 empties the FIFO.
      DRAIN: if (pop && fifo_count == 2'd1) state_nxt = DONE;
      DONE: begin
        pdone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  unreg_skid2 #(.W(W)) u_fifo (
    .clk       (pclk),
    .rst_n     (rst_sync_n),
    .push      (accept),
    .din       (word),
    .out_ready (pout_ready),
    .out_valid (pout_valid),
    .dout      (pout),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_unreg_capture.sv
`default_nettype none
// tb_unreg_capture: directed and random bursts checked against a queue-based reference model.
module tb_unreg_capture;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             pclk = 1'b0;
  logic             prst_n = 1'b0;
  logic             pstart = 1'b0;
  logic [CNT_W-1:0] plen = '0;
  logic             pin_valid = 1'b0;
  logic             pin_ready;
  logic [W-1:0]     pa = '0;
  logic [W-1:0]     pb = '0;
  logic             psel = 1'b0;
  logic             pclr = 1'b0;
  logic             pinv = 1'b0;
  logic             pout_valid;
  logic             pout_ready = 1'b0;
  logic [W-1:0]     pout;
  logic             pbusy;
  logic             pdone;

  always #5 pclk = ~pclk;

  unreg_capture #(.W(W), .CNT_W(CNT_W)) dut (
    .pclk       (pclk),
    .prst_n     (prst_n),
    .pstart     (pstart),
    .plen       (plen),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .pa         (pa),
    .pb         (pb),
    .psel       (psel),
    .pclr       (pclr),
    .pinv       (pinv),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .pout       (pout),
    .pbusy      (pbusy),
    .pdone      (pdone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending words in order, words still to accept, burst flags.
  logic [W-1:0] q[$];
  int           rem = 0;
  bit           active = 1'b0;
  bit           done_pulse = 1'b0;
  int           accepts = 0;

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sel, input logic clr, input logic inv);
    logic [W-1:0] f;
    if (clr)      f = '0;
    else if (sel) f = b;
    else          f = a;
    return inv ? ~f : f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return active && rem > 0 && q.size() < 2;
  endfunction

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic cycle();
    bit           exp_valid;
    bit           acc;
    bit           pp;
    bit           drain;
    bit           dp_next;
    logic [W-1:0] exp_out;
    exp_valid = q.size() > 0;
    exp_out   = exp_valid ? q[0] : '0;
    chk("pin_ready",  {31'b0, pin_ready},  {31'b0, model_ready()});
    chk("pout_valid", {31'b0, pout_valid}, {31'b0, exp_valid});
    chk("pout",       {16'b0, pout},       {16'b0, exp_out});
    chk("pbusy",      {31'b0, pbusy},      {31'b0, active || done_pulse});
    chk("pdone",      {31'b0, pdone},      {31'b0, done_pulse});
    acc   = pin_valid && model_ready();
    pp    = exp_valid && pout_ready;
    drain = active && rem == 0;
    dp_next = 1'b0;
    @(posedge pclk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(ref_word(pa, pb, psel, pclr, pinv));
      rem--;
      accepts++;
    end
    if (drain && pp && q.size() == 0) begin
      active  = 1'b0;
      dp_next = 1'b1;
    end else if (!active && !done_pulse && pstart) begin
      active = 1'b1;
      rem    = (plen == '0) ? (1 << CNT_W) : int'(plen);
    end
    done_pulse = dp_next;
    @(negedge pclk);
  endtask

  task automatic apply_reset();
    #2 prst_n = 1'b0;
    #1;
    chk("rst_pin_ready",  {31'b0, pin_ready},  32'd0);
    chk("rst_pout_valid", {31'b0, pout_valid}, 32'd0);
    chk("rst_pout",       {16'b0, pout},       32'd0);
    chk("rst_pbusy",      {31'b0, pbusy},      32'd0);
    chk("rst_pdone",      {31'b0, pdone},      32'd0);
    q.delete();
    rem = 0; active = 1'b0; done_pulse = 1'b0;
    pstart = 1'b0; pin_valid = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    prst_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic start_burst(input int len);
    plen   = len[CNT_W-1:0];
    pstart = 1'b1;
    cycle();
    pstart = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sel, input logic clr, input logic inv);
    bit was;
    bit ok;
    pa = a; pb = b; psel = sel; pclr = clr; pinv = inv;
    pin_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      was = model_ready();
      cycle();
      if (was) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    pin_valid = 1'b0;
  endtask

  task automatic finish_burst();
    pin_valid  = 1'b0;
    pstart     = 1'b0;
    pout_ready = 1'b1;
    for (int i = 0; i < 2000 && (active || done_pulse); i++) cycle();
    if (active || done_pulse) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) cycle();
  endtask

  task automatic random_inputs();
    pa   = W'($urandom);
    pb   = W'($urandom);
    psel = 1'($urandom);
    pclr = ($urandom_range(0, 3) == 0);
    pinv = 1'($urandom);
  endtask

  initial begin
    @(negedge pclk);
    apply_reset();

    // Directed burst of three with a free-running consumer.
    pout_ready = 1'b1;
    start_burst(3);
    send(16'h00FF, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    chk("t1_w0", {16'b0, pout}, 32'h00FF);
    send(16'h00FF, 16'hF0F0, 1'b1, 1'b0, 1'b0);
    chk("t1_w1", {16'b0, pout}, 32'hF0F0);
    send(16'h00FF, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    chk("t1_w2", {16'b0, pout}, 32'h00FF);
    finish_burst();

    // Clear plus invert gives all ones; invert of selected B.
    start_burst(2);
    send(W'($urandom), W'($urandom), 1'b0, 1'b1, 1'b1);
    chk("t2_ones0", {16'b0, pout}, 32'hFFFF);
    send(W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b1);
    chk("t2_ones1", {16'b0, pout}, 32'hFFFF);
    finish_burst();
    pout_ready = 1'b0;
    start_burst(1);
    send(W'($urandom), 16'h1234, 1'b1, 1'b0, 1'b1);
    chk("t2_edcb", {16'b0, pout}, 32'hEDCB);
    finish_burst();

    // Backpressure: FIFO fills, then a pop with valid held shows no same-cycle accept.
    pout_ready = 1'b0;
    start_burst(4);
    pin_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      random_inputs();
      cycle();
    end
    chk("bp_full_ready", {31'b0, pin_ready}, 32'd0);
    pout_ready = 1'b1;
    for (int i = 0; i < 20 && active && rem > 0; i++) begin
      random_inputs();
      cycle();
    end
    finish_burst();

    // plen=0 means 256 words; pstart pulses mid-burst must not reload the count.
    accepts = 0;
    start_burst(0);
    for (int i = 0; i < 4000 && active; i++) begin
      pin_valid  = ($urandom_range(0, 3) != 0);
      pout_ready = ($urandom_range(0, 3) != 0);
      pstart     = ($urandom_range(0, 15) == 0);
      plen       = CNT_W'($urandom_range(1, 9));
      random_inputs();
      cycle();
    end
    finish_burst();
    chk("len256_accepts", accepts, 32'd256);

    // Random short bursts with random handshakes.
    for (int b = 0; b < 6; b++) begin
      start_burst($urandom_range(1, 6));
      for (int i = 0; i < 300 && active; i++) begin
        pin_valid  = 1'($urandom);
        pout_ready = 1'($urandom);
        random_inputs();
        cycle();
      end
      finish_burst();
    end

    // Reset in the middle of a burst discards everything and emits no pdone.
    pout_ready = 1'b0;
    start_burst(5);
    send(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
    send(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0);
    apply_reset();
    pout_ready = 1'b1;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
